// File: rtl/neuron_pkg.sv
// Shared types, sizes and default weight/bias sets
// for the 7x7 four-neuron scoring block.
package neuron_pkg;

    localparam int WIN   = 7;
    localparam int PIX_W = 8;
    localparam int N_OUT = 4;

    typedef logic        [7:0]  pixel_t;
    typedef logic signed [7:0]  weight_t;
    typedef logic signed [15:0] bias_t;
    typedef logic signed [23:0] acc_t;

    typedef weight_t [WIN-1:0][WIN-1:0] w_grid_t;
    typedef w_grid_t [N_OUT-1:0]        w_set_t;
    typedef bias_t   [N_OUT-1:0]        b_set_t;

    // Neuron 0 sums all, 1 picks column 3, 2 picks row 3, 3 negates all.
    function automatic w_set_t w_default();
        w_set_t w;
        w = '0;
        for (int k = 0; k < N_OUT; k++) begin
            for (int r = 0; r < WIN; r++) begin
                for (int c = 0; c < WIN; c++) begin
                    unique case (1'b1)
                        (k == 0): w[k][r][c] = 8'sd1;
                        (k == 1): w[k][r][c] = (c == 3) ? 8'sd1 : 8'sd0;
                        (k == 2): w[k][r][c] = (r == 3) ? 8'sd1 : 8'sd0;
                        default:  w[k][r][c] = -8'sd1;
                    endcase
                end
            end
        end
        return w;
    endfunction

    localparam w_set_t W_DEFAULT = w_default();
    localparam b_set_t B_DEFAULT = {16'sd100, 16'sd0, 16'sd0, 16'sd0};

endpackage

// File: rtl/neuron_dot.sv
// One neuron: registered row sums, then total + bias + optional ReLU
// into a sign-extended 32-bit score register.
module neuron_dot
    import neuron_pkg::*;
#(
    parameter bit      RELU_EN = 1'b1,
    parameter w_grid_t WEIGHTS = '0,
    parameter bias_t   BIAS    = '0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     v1,
    input  logic                     v2,
    input  logic [WIN*WIN*PIX_W-1:0] pix,
    output logic [31:0]              score
);

    typedef logic signed [16:0] prod_t;
    typedef logic signed [19:0] row_t;
    typedef logic signed [22:0] tot_t;

    prod_t prod  [WIN][WIN];
    row_t  row_d [WIN];
    row_t  row_q [WIN];
    tot_t  tot;
    acc_t  acc;
    acc_t  res;

    // Pixels are unsigned, so widen with a zero sign bit before the signed MAC.
    always_comb begin
        for (int r = 0; r < WIN; r++) begin
            for (int c = 0; c < WIN; c++) begin
                prod[r][c] = 17'($signed({1'b0, pix[(r*WIN+c)*PIX_W +: PIX_W]}))
                           * 17'($signed(WEIGHTS[r][c]));
            end
        end
    end

    always_comb begin
        for (int r = 0; r < WIN; r++) begin
            row_d[r] = '0;
            for (int c = 0; c < WIN; c++) begin
                row_d[r] = row_d[r] + 20'(prod[r][c]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int r = 0; r < WIN; r++) begin
                row_q[r] <= '0;
            end
        end else if (v1) begin
            for (int r = 0; r < WIN; r++) begin
                row_q[r] <= row_d[r];
            end
        end
    end

    always_comb begin
        tot = '0;
        for (int r = 0; r < WIN; r++) begin
            tot = tot + 23'(row_q[r]);
        end
        acc = 24'(tot) + 24'(BIAS);
        res = (RELU_EN && (acc < 0)) ? '0 : acc;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            score <= '0;
        end else if (v2) begin
            score <= 32'(res);
        end
    end

endmodule

// File: rtl/neuron_unit.sv
// Four-neuron 7x7 window scorer: window capture stage and valid
// pipeline feeding one neuron_dot per output symbol.
module neuron_unit
    import neuron_pkg::*;
#(
    parameter bit     RELU_EN = 1'b1,
    parameter w_set_t WEIGHTS = W_DEFAULT,
    parameter b_set_t BIASES  = B_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        de_in,
    input  logic [55:0] line_0_in,
    input  logic [55:0] line_1_in,
    input  logic [55:0] line_2_in,
    input  logic [55:0] line_3_in,
    input  logic [55:0] line_4_in,
    input  logic [55:0] line_5_in,
    input  logic [55:0] line_6_in,
    output logic [31:0] symbol_0,
    output logic [31:0] symbol_1,
    output logic [31:0] symbol_2,
    output logic [31:0] symbol_3
);

    localparam int LINE_W = WIN * PIX_W;
    localparam int PIX_N  = WIN * WIN * PIX_W;

    logic [LINE_W-1:0] line [WIN];
    logic [PIX_N-1:0]  pix_d;
    logic [PIX_N-1:0]  pix_q;
    logic              v1;
    logic              v2;
    logic [31:0]       sym [N_OUT];

    assign line[0] = line_0_in;
    assign line[1] = line_1_in;
    assign line[2] = line_2_in;
    assign line[3] = line_3_in;
    assign line[4] = line_4_in;
    assign line[5] = line_5_in;
    assign line[6] = line_6_in;

    // Column 0 sits in the top byte of each row bus.
    always_comb begin
        pix_d = '0;
        for (int r = 0; r < WIN; r++) begin
            for (int c = 0; c < WIN; c++) begin
                pix_d[(r*WIN+c)*PIX_W +: PIX_W] =
                    line[r][LINE_W-1-c*PIX_W -: PIX_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            v1    <= 1'b0;
            v2    <= 1'b0;
            pix_q <= '0;
        end else begin
            v1 <= de_in;
            v2 <= v1;
            if (de_in) begin
                pix_q <= pix_d;
            end
        end
    end

    for (genvar k = 0; k < N_OUT; k++) begin : g_dot
        neuron_dot #(
            .RELU_EN (RELU_EN),
            .WEIGHTS (WEIGHTS[k]),
            .BIAS    (BIASES[k])
        ) u_dot (
            .clk   (clk),
            .reset (reset),
            .v1    (v1),
            .v2    (v2),
            .pix   (pix_q),
            .score (sym[k])
        );
    end

    assign symbol_0 = sym[0];
    assign symbol_1 = sym[1];
    assign symbol_2 = sym[2];
    assign symbol_3 = sym[3];

endmodule

// File: tb/tb_neuron_unit.sv
// Scoreboard bench for neuron_unit: ReLU and non-ReLU instances
// share stimulus; expected scores come from a bench-side model.
module tb_neuron_unit;

    typedef struct packed {
        logic [3:0][31:0] r;
        logic [3:0][31:0] n;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        de_in;
    logic [55:0] lines [7];
    logic [31:0] s_r [4];
    logic [31:0] s_n [4];

    int   checks = 0;
    int   errors = 0;
    exp_t sbq [$];
    exp_t exp_r = '0;
    logic d1 = 1'b0;
    logic d2 = 1'b0;
    logic armed = 1'b0;
    logic under = 1'b0;

    always #5 clk = ~clk;

    neuron_unit u_dut (
        .clk(clk), .reset(reset), .de_in(de_in),
        .line_0_in(lines[0]), .line_1_in(lines[1]), .line_2_in(lines[2]),
        .line_3_in(lines[3]), .line_4_in(lines[4]), .line_5_in(lines[5]),
        .line_6_in(lines[6]),
        .symbol_0(s_r[0]), .symbol_1(s_r[1]),
        .symbol_2(s_r[2]), .symbol_3(s_r[3])
    );

    neuron_unit #(.RELU_EN(1'b0)) u_nr (
        .clk(clk), .reset(reset), .de_in(de_in),
        .line_0_in(lines[0]), .line_1_in(lines[1]), .line_2_in(lines[2]),
        .line_3_in(lines[3]), .line_4_in(lines[4]), .line_5_in(lines[5]),
        .line_6_in(lines[6]),
        .symbol_0(s_n[0]), .symbol_1(s_n[1]),
        .symbol_2(s_n[2]), .symbol_3(s_n[3])
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d",
                     tag, $signed(got), $signed(exp));
        end
    endtask

    function automatic int wt(input int k, input int r, input int c);
        if (k == 0) return 1;
        if (k == 1) return (c == 3) ? 1 : 0;
        if (k == 2) return (r == 3) ? 1 : 0;
        return -1;
    endfunction

    function automatic exp_t model(input logic [6:0][55:0] ln);
        exp_t e;
        int   acc;
        int   p;
        e = '0;
        for (int k = 0; k < 4; k++) begin
            acc = (k == 3) ? 100 : 0;
            for (int r = 0; r < 7; r++) begin
                for (int c = 0; c < 7; c++) begin
                    p = int'(ln[r][55-8*c -: 8]);
                    acc += p * wt(k, r, c);
                end
            end
            e.n[k] = acc;
            e.r[k] = (acc < 0) ? 0 : acc;
        end
        return e;
    endfunction

    always @(posedge clk) begin
        under <= 1'b0;
        if (!reset) begin
            sbq.delete();
            d1    <= 1'b0;
            d2    <= 1'b0;
            exp_r <= '0;
            armed <= 1'b1;
        end else begin
            if (d2) begin
                if (sbq.size() == 0) under <= 1'b1;
                else exp_r <= sbq.pop_front();
            end
            d2 <= d1;
            d1 <= de_in;
            if (de_in) begin
                sbq.push_back(model({lines[6], lines[5], lines[4], lines[3],
                                     lines[2], lines[1], lines[0]}));
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            if (under) check("sb_underflow", 32'(under), 32'd0);
            for (int k = 0; k < 4; k++) begin
                check($sformatf("sym_relu%0d", k), s_r[k], exp_r.r[k]);
                check($sformatf("sym_raw%0d", k), s_n[k], exp_r.n[k]);
            end
        end
    end

    // mode 0: all pixels = v; mode 1: only (3,3) = v; mode 2: random
    task automatic send(input int mode, input int v);
        @(negedge clk);
        for (int r = 0; r < 7; r++) begin
            for (int c = 0; c < 7; c++) begin
                case (mode)
                    0:       lines[r][55-8*c -: 8] = 8'(v);
                    1:       lines[r][55-8*c -: 8] = (r == 3 && c == 3) ? 8'(v) : 8'd0;
                    default: lines[r][55-8*c -: 8] = 8'($urandom_range(0, 255));
                endcase
            end
        end
        de_in = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            de_in = 1'b0;
            for (int r = 0; r < 7; r++) lines[r] = 'x;
        end
    endtask

    initial begin
        reset = 1'b0;
        de_in = 1'b0;
        for (int r = 0; r < 7; r++) lines[r] = '0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        idle(3);
        check("rst_s0", s_r[0], 32'd0);

        send(0, 0);
        idle(4);
        check("zero_s3", s_r[3], 32'd100);
        check("zero_s0", s_r[0], 32'd0);

        send(0, 255);
        idle(4);
        check("ff_s0", s_r[0], 32'd12495);
        check("ff_s1", s_r[1], 32'd1785);
        check("ff_s2", s_r[2], 32'd1785);
        check("ff_s3_relu", s_r[3], 32'd0);
        check("ff_s3_raw", s_n[3], 32'(-12395));

        send(1, 200);
        idle(4);
        check("pt_s0", s_r[0], 32'd200);
        check("pt_s1", s_r[1], 32'd200);
        check("pt_s2", s_r[2], 32'd200);
        check("pt_s3", s_r[3], 32'd0);

        send(0, 0);
        send(0, 255);
        idle(5);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 2) != 0) send(2, 0);
            else idle(1);
        end
        idle(4);

        send(0, 255);
        idle(4);
        send(0, 0);
        @(negedge clk);
        de_in = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        idle(6);
        check("rst_flush_s0", s_r[0], 32'd0);
        check("rst_flush_s3", s_r[3], 32'd0);

        send(2, 0);
        idle(6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
